// File: rtl/sched_pkg.sv
// sched_pkg: shared thread-scheduler types, bank mapping and one-hot helpers
package sched_pkg;

    localparam int NUM_THREADS = 4;

    typedef enum logic {RUN, HOLD} state_e;

    function automatic logic bank_of(input logic [1:0] t);
        return 1'(t & 2'd1);
    endfunction

    function automatic logic [3:0] onehot4_enc(input logic [1:0] t);
        return 4'b0001 << t;
    endfunction

    function automatic logic [1:0] onehot4_dec(input logic [3:0] oh);
        return {oh[3] | oh[2], oh[3] | oh[1]};
    endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// rr_arbiter4: combinational 4-way round-robin arbiter, search starts after ptr_i
module rr_arbiter4 (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic [3:0] gnt_o,
    output logic       found_o
);

    logic [1:0] idx;

    // walk ptr+1 .. ptr+4 and grant the first requester
    always_comb begin
        gnt_o   = '0;
        found_o = 1'b0;
        idx     = '0;
        for (int i = 1; i <= 4; i++) begin
            idx = ptr_i + 2'(i);
            if (!found_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                found_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/thread_scheduler.sv
// thread_scheduler: bank-conflict-aware round-robin issue scheduler; SCHED_BANK_ALT_EN enables bank-alternation preference
module thread_scheduler
    import sched_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_THREADS-1:0] thread_en,
    input  logic [NUM_THREADS-1:0] thread_stall,
    input  logic                   ctrl_MEM,
    input  logic [NUM_THREADS-1:0] thread_sel_MEM,
    input  logic                   pipe_hold,
    output logic [NUM_THREADS-1:0] thread_sel_ID,
    output logic                   issue_valid,
    output logic [CNT_W-1:0]       conflict_cnt,
    output logic [CNT_W-1:0]       bubble_cnt
);

    state_e           state_q, state_d;
    logic [3:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] conf_q, conf_d, bub_q, bub_d;
    logic [1:0]       wb_bank_busy;
    logic [3:0]       busy_t, cand, elig, req, gnt;
    logic             found, go;

    // a bank being written back this cycle cannot also be read by ID
    always_comb begin
        wb_bank_busy = {2{ctrl_MEM}} & (thread_sel_MEM[1:0] | thread_sel_MEM[3:2]);
        busy_t = '0;
        for (int t = 0; t < 4; t++) busy_t[t] = wb_bank_busy[bank_of(2'(t))];
        cand = thread_en & ~thread_stall;
        elig = cand & ~busy_t;
`ifdef SCHED_BANK_ALT_EN
        req = |(elig & (last_q[0] ? 4'b0101 : 4'b1010)) ? elig & (last_q[0] ? 4'b0101 : 4'b1010) : elig;
`else
        req = elig;
`endif
    end

    rr_arbiter4 u_arb (
        .req_i   (req),
        .ptr_i   (last_q),
        .gnt_o   (gnt),
        .found_o (found)
    );

    // issue FSM: arbitrate whenever the front end is not frozen, otherwise hold everything
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (pipe_hold) state_d = HOLD;
            HOLD:    if (!pipe_hold) state_d = RUN;
            default: state_d = RUN;
        endcase
        go     = !pipe_hold;
        sel_d  = go ? gnt : sel_q;
        last_d = go && found ? onehot4_dec(gnt) : last_q;
        conf_d = go && |(cand & busy_t) && !(&conf_q) ? conf_q + 1'b1 : conf_q;
        bub_d  = go && !found && |thread_en && !(&bub_q) ? bub_q + 1'b1 : bub_q;
    end

    // state, selection, pointer and counter registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            sel_q   <= '0;
            last_q  <= 2'd3;
            conf_q  <= '0;
            bub_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            conf_q  <= conf_d;
            bub_q   <= bub_d;
        end
    end

    assign thread_sel_ID = sel_q;
    assign issue_valid   = |sel_q;
    assign conflict_cnt  = conf_q;
    assign bubble_cnt    = bub_q;

    a_sel_mem_onehot: assert property (@(posedge clk) disable iff (reset)
        ctrl_MEM |-> $onehot(thread_sel_MEM));

endmodule

// File: tb/tb_thread_scheduler.sv
// tb_thread_scheduler: directed plus randomized checks against a behavioural scheduler model
module tb_thread_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] thread_en = '0, thread_stall = '0, thread_sel_MEM = 4'b0001;
    logic       ctrl_MEM = 1'b0, pipe_hold = 1'b0;
    logic [3:0] thread_sel_ID;
    logic       issue_valid;
    logic [15:0] conflict_cnt, bubble_cnt;

    int n_cmp = 0, n_err = 0;
    int m_sel = 0, m_last = 3, m_conf = 0, m_bub = 0;

    thread_scheduler dut (
        .clk            (clk),
        .reset          (reset),
        .thread_en      (thread_en),
        .thread_stall   (thread_stall),
        .ctrl_MEM       (ctrl_MEM),
        .thread_sel_MEM (thread_sel_MEM),
        .pipe_hold      (pipe_hold),
        .thread_sel_ID  (thread_sel_ID),
        .issue_valid    (issue_valid),
        .conflict_cnt   (conflict_cnt),
        .bubble_cnt     (bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input logic [3:0] en, input logic [3:0] st, input logic cm,
                         input logic [3:0] sm, input logic hd, input logic rs);
        bit busy[2];
        bit ok[4];
        bit conf;
        int g, t;
        conf = 0;
        g = -1;
        if (rs) begin
            m_sel = 0; m_last = 3; m_conf = 0; m_bub = 0;
        end else if (!hd) begin
            busy[0] = cm && (sm[0] || sm[2]);
            busy[1] = cm && (sm[1] || sm[3]);
            for (int k = 0; k < 4; k++) begin
                ok[k] = en[k] && !st[k] && !busy[k % 2];
                if (en[k] && !st[k] && busy[k % 2]) conf = 1;
            end
`ifdef SCHED_BANK_ALT_EN
            for (int k = 1; k <= 4; k++) begin
                t = (m_last + k) % 4;
                if (g < 0 && ok[t] && (t % 2) != (m_last % 2)) g = t;
            end
`endif
            for (int k = 1; k <= 4; k++) begin
                t = (m_last + k) % 4;
                if (g < 0 && ok[t]) g = t;
            end
            if (g >= 0) begin
                m_sel = 1 << g;
                m_last = g;
            end else m_sel = 0;
            if (conf && m_conf < 65535) m_conf++;
            if (g < 0 && en != 0 && m_bub < 65535) m_bub++;
        end
    endtask

    task automatic step(input logic [3:0] en, input logic [3:0] st, input logic cm,
                        input logic [3:0] sm, input logic hd, input logic rs);
        @(negedge clk);
        thread_en = en; thread_stall = st; ctrl_MEM = cm;
        thread_sel_MEM = sm; pipe_hold = hd; reset = rs;
        model(en, st, cm, sm, hd, rs);
        @(posedge clk);
        #1;
        check("sel", 32'(thread_sel_ID), 32'(m_sel));
        check("valid", 32'(issue_valid), 32'(m_sel != 0));
        check("conflict_cnt", 32'(conflict_cnt), 32'(m_conf));
        check("bubble_cnt", 32'(bubble_cnt), 32'(m_bub));
    endtask

    initial begin
        step(4'b0000, 4'b0000, 0, 4'b0001, 0, 1);
        check("reset_sel", 32'(thread_sel_ID), 32'h0);
        repeat (5) step(4'b1111, 4'b0000, 0, 4'b0001, 0, 0);
        step(4'b0000, 4'b0000, 0, 4'b0001, 0, 1);
        step(4'b1111, 4'b0000, 0, 4'b0001, 0, 0);
        check("first_grant", 32'(thread_sel_ID), 32'h1);
        step(4'b0000, 4'b0000, 0, 4'b0001, 0, 1);
        step(4'b0101, 4'b0000, 1, 4'b0001, 0, 0);
        check("conflict_sel", 32'(thread_sel_ID), 32'h0);
        check("conflict_one", 32'(conflict_cnt), 32'h1);
        check("bubble_one", 32'(bubble_cnt), 32'h1);
        step(4'b0000, 4'b0000, 0, 4'b0001, 0, 1);
        repeat (6) step(4'b1111, 4'b0010, 0, 4'b0001, 0, 0);
        step(4'b0000, 4'b0000, 0, 4'b0001, 0, 1);
        repeat (3) step(4'b1111, 4'b0000, 0, 4'b0001, 0, 0);
        step(4'b0101, 4'b0000, 1, 4'b0100, 1, 0);
        step(4'b0000, 4'b1111, 1, 4'b0010, 1, 0);
        step(4'b1111, 4'b0000, 0, 4'b0001, 1, 0);
        check("hold_sel", 32'(thread_sel_ID), 32'h4);
        step(4'b1111, 4'b0000, 0, 4'b0001, 0, 0);
        check("after_hold", 32'(thread_sel_ID), 32'h8);
        step(4'b0101, 4'b0000, 1, 4'b0001, 0, 0);
        step(4'b1111, 4'b0000, 0, 4'b0001, 1, 0);
        step(4'b1111, 4'b0000, 0, 4'b0001, 1, 1);
        check("hold_reset_sel", 32'(thread_sel_ID), 32'h0);
        check("hold_reset_cnt", 32'(conflict_cnt), 32'h0);
        step(4'b1111, 4'b0000, 0, 4'b0001, 0, 0);
        check("post_reset_grant", 32'(thread_sel_ID), 32'h1);
        step(4'b0000, 4'b0000, 0, 4'b0001, 0, 1);
        step(4'b0001, 4'b0000, 0, 4'b0001, 0, 0);
        repeat (20) step(4'b0111, 4'b0000, 0, 4'b0001, 0, 0);
        for (int i = 0; i < 2000; i++) begin
            step(4'($urandom_range(15)), ($urandom_range(3) == 0) ? 4'($urandom_range(15)) : 4'b0000,
                 1'($urandom_range(1)), 4'b0001 << $urandom_range(3),
                 $urandom_range(7) == 0, $urandom_range(99) == 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
